alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command-side partner of alu8: accepts ALU operation requests, fetches the B operand,
//  drives alu8 (regA/regB/opcode/carryIn), then writes res/flagsOut back into the
//  architectural A and F registers.
//  Sits between the instruction decoder and alu8; owns A and F for all ALU-class ops.
// PARAMETERS
//  RESET_A      8'h01  value of A after reset
//  RESET_F      8'hB0  value of F after reset (bits [3:0] must be 0)
//  MEM_TIMEOUT  15     max wait cycles in FETCH before abort (1..255)
// PORTS
//  clk         in   1   clock, rising edge
//  resetN      in   1   asynchronous active-low reset
//  reqValid    in   1   request valid
//  reqReady    out  1   block can accept request
//  reqOp       in   4   alu8 opcode encoding (ADD=0 .. RR=9)
//  reqSrc      in   1   0: B=reqOperand; 1: B=mem[reqAddr] (MEM_OPERAND_EN only)
//  reqOperand  in   8   immediate/register B operand
//  reqAddr     in   16  memory operand address
//  memRdReq    out  1   memory read request, held until memRdValid
//  memAddr     out  16  memory read address
//  memRdValid  in   1   read data valid
//  memRdData   in   8   read data
//  aluA/aluB   out  8   to alu8 regA/regB
//  aluOp       out  4   to alu8 opcode
//  aluCarry    out  1   to alu8 carryIn (= F[4])
//  aluRes      in   8   from alu8 res
//  aluFlags    in   8   from alu8 flagsOut
//  loadA       in   1   direct load of A
//  loadData    in   8   value for loadA
//  regAOut     out  8   current A
//  regFOut     out  8   current F
//  done        out  1   1-cycle pulse: op retired
//  opErr       out  1   1-cycle pulse with done: illegal opcode or memory timeout
// BEHAVIOUR
//  Reset (async, resetN=0): A=RESET_A, F=RESET_F, state=IDLE.
//   All other outputs 0, except reqReady=1 once resetN deasserts.
//  FSM: IDLE -> (accept, reqSrc=0) EXEC; IDLE -> (accept, reqSrc=1) FETCH;
//   FETCH -> (memRdValid) EXEC; FETCH -> (timeout) IDLE; EXEC -> IDLE.
//  Accept = reqValid & reqReady. reqReady=1 only in IDLE.
//   Op, src, operand and addr are latched at accept.
//  FETCH: memRdReq=1, memAddr=latched addr.
//   memRdData captured into B latch on the edge where memRdValid=1.
//   Wait counter starts at 0 and increments each FETCH cycle without memRdValid.
//   Reaching MEM_TIMEOUT -> back to IDLE with done=1, opErr=1; A/F unchanged.
//  EXEC (exactly 1 cycle): aluA=A, aluB=B latch, aluOp=latched op, aluCarry=F[4].
//   At the closing edge: F <= {aluFlags[7:4],4'b0}; A <= aluRes, except CP (4'b0100).
//   done=1 in the following cycle.
//  Opcodes 10..15: no writeback; done=1 and opErr=1; A/F unchanged.
//  Latency, immediate source: accept at edge k; A/F updated and done=1 in cycle k+2.
//   reqReady=1 in cycle k+2, so max throughput is 1 op / 2 cycles.
//  aluA/aluB/aluOp/aluCarry = 0 outside EXEC.
//  loadA: honoured only in IDLE, ignored otherwise.
//   If loadA and accept occur on the same edge, EXEC uses the new A.
//  reset mid-operation: immediate return to IDLE.
//   A/F forced to reset values; memRdReq drops; no done.
// CONFIGURATION
//  MEM_OPERAND_EN defined: reqSrc honoured; FETCH, timeout and memory ports active.
//  MEM_OPERAND_EN undefined: reqSrc ignored (treated as 0); memRdReq=0, memAddr=0;
//   FETCH unreachable; memRdValid/memRdData unused.
// TESTING
//  1 Reset: resetN=0 -> regAOut=01, regFOut=B0, reqReady=0 during reset then 1, done=0.
//  2 ADD imm: A=3A, op=0, operand=C6 -> 2 cycles later A=00, F=B0, done 1 cycle.
//  3 ADC: F=10, A=E1, op=1, operand=0F -> A=F1, F=20.
//    Then CP: op=4, operand=2F with A=3C -> F=60, A stays 3C.
//  4 Mem SUB (MEM_OPERAND_EN): A=01, op=2, reqSrc=1, reqAddr=C000.
//    memRdValid after 3 cycles with data 01 -> memAddr=C000, A=00, F=C0.
//    No memRdValid -> done+opErr after MEM_TIMEOUT cycles; A/F unchanged.
//  5 Illegal op=C -> done+opErr; A/F unchanged.
//    Back-to-back ADD requests: reqReady low in EXEC, second op retires 2 cycles later.
//  6 resetN pulse during FETCH -> A=01, F=B0, memRdReq=0, no done.
//    loadA=1 with data 55 during EXEC is ignored.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts ALU requests, fetches B, drives alu8 and owns the A/F registers.
// Optional memory-operand path enabled by defining MEM_OPERAND_EN.
module alu_op_sequencer #(
  parameter logic [7:0]  RESET_A     = 8'h01,
  parameter logic [7:0]  RESET_F     = 8'hB0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [3:0]  reqOp,
  input  logic        reqSrc,
  input  logic [7:0]  reqOperand,
  input  logic [15:0] reqAddr,
  output logic        memRdReq,
  output logic [15:0] memAddr,
  input  logic        memRdValid,
  input  logic [7:0]  memRdData,
  output logic [7:0]  aluA,
  output logic [7:0]  aluB,
  output logic [3:0]  aluOp,
  output logic        aluCarry,
  input  logic [7:0]  aluRes,
  input  logic [7:0]  aluFlags,
  input  logic        loadA,
  input  logic [7:0]  loadData,
  output logic [7:0]  regAOut,
  output logic [7:0]  regFOut,
  output logic        done,
  output logic        opErr
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  localparam logic [3:0] OP_CP        = 4'd4;
  localparam logic [3:0] OP_LAST      = 4'd9;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [7:0]  b_q;
  logic [7:0]  a_q;
  logic [7:0]  f_q;
  logic [7:0]  wait_cnt;
  logic        done_q;
  logic        err_q;
  logic        accept;
  logic        src_eff;
  logic        mem_valid;
  logic [7:0]  mem_data;
  logic        timeout;

`ifdef MEM_OPERAND_EN
  logic [15:0] addr_q;
  logic        unused_flags;

  assign src_eff   = reqSrc;
  assign mem_valid = memRdValid;
  assign mem_data  = memRdData;
  assign memRdReq  = (state == FETCH);
  assign memAddr   = (state == FETCH) ? addr_q : 16'h0000;
  assign unused_flags = ^aluFlags[3:0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      addr_q <= 16'h0000;
    else if (accept)
      addr_q <= reqAddr;
  end
`else
  // Memory-operand path compiled out: FETCH is unreachable and the memory inputs are sunk here.
  logic unused_mem;

  assign src_eff    = 1'b0;
  assign mem_valid  = 1'b0;
  assign mem_data   = 8'h00;
  assign memRdReq   = 1'b0;
  assign memAddr    = 16'h0000;
  assign unused_mem = ^{reqSrc, reqAddr, memRdValid, memRdData, aluFlags[3:0]};
`endif

  // Gate with resetN so no request is accepted while reset is held.
  assign reqReady = resetN && (state == IDLE);
  assign accept   = reqValid && reqReady;
  assign timeout  = (state == FETCH) && !mem_valid && (wait_cnt == TIMEOUT_LAST);

  assign aluA     = (state == EXEC) ? a_q    : 8'h00;
  assign aluB     = (state == EXEC) ? b_q    : 8'h00;
  assign aluOp    = (state == EXEC) ? op_q   : 4'h0;
  assign aluCarry = (state == EXEC) ? f_q[4] : 1'b0;

  assign regAOut = a_q;
  assign regFOut = f_q;
  assign done    = done_q;
  assign opErr   = err_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = src_eff ? FETCH : EXEC;
      FETCH: begin
        if (mem_valid)    state_nxt = EXEC;
        else if (timeout) state_nxt = IDLE;
      end
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      op_q     <= 4'h0;
      b_q      <= 8'h00;
      a_q      <= RESET_A;
      f_q      <= RESET_F;
      wait_cnt <= 8'h00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (loadA) a_q <= loadData;
          if (accept) begin
            op_q     <= reqOp;
            b_q      <= reqOperand;
            wait_cnt <= 8'h00;
          end
        end
        FETCH: begin
          if (mem_valid) begin
            b_q <= mem_data;
          end else if (timeout) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        EXEC: begin
          done_q <= 1'b1;
          if (op_q > OP_LAST) begin
            err_q <= 1'b1;
          end else begin
            f_q <= {aluFlags[7:4], 4'b0000};
            if (op_q != OP_CP) a_q <= aluRes;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural alu8 responder.
// Memory-operand steps are exercised when MEM_OPERAND_EN is defined.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        reqValid;
  logic        reqReady;
  logic [3:0]  reqOp;
  logic        reqSrc;
  logic [7:0]  reqOperand;
  logic [15:0] reqAddr;
  logic        memRdReq;
  logic [15:0] memAddr;
  logic        memRdValid;
  logic [7:0]  memRdData;
  logic [7:0]  aluA, aluB;
  logic [3:0]  aluOp;
  logic        aluCarry;
  logic [7:0]  aluRes, aluFlags;
  logic        loadA;
  logic [7:0]  loadData;
  logic [7:0]  regAOut, regFOut;
  logic        done, opErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp), .reqSrc(reqSrc),
    .reqOperand(reqOperand), .reqAddr(reqAddr),
    .memRdReq(memRdReq), .memAddr(memAddr), .memRdValid(memRdValid), .memRdData(memRdData),
    .aluA(aluA), .aluB(aluB), .aluOp(aluOp), .aluCarry(aluCarry),
    .aluRes(aluRes), .aluFlags(aluFlags),
    .loadA(loadA), .loadData(loadData),
    .regAOut(regAOut), .regFOut(regFOut), .done(done), .opErr(opErr)
  );

  // alu8 stand-in: flags are {Z,N,H,C} in [7:4]; low nibble is deliberately nonzero.
  logic [8:0] t;
  logic       fz, fn, fh, fc;
  always_comb begin
    t  = 9'h000;
    fn = 1'b0;
    fh = 1'b0;
    fc = 1'b0;
    case (aluOp)
      4'd0: begin t = aluA + aluB; fh = (aluA[3:0] + aluB[3:0]) > 5'd15; fc = t[8]; end
      4'd1: begin
        t  = aluA + aluB + {8'h00, aluCarry};
        fh = (aluA[3:0] + aluB[3:0] + {4'h0, aluCarry}) > 5'd15;
        fc = t[8];
      end
      4'd2, 4'd4: begin
        t = {1'b0, aluA} - {1'b0, aluB}; fn = 1'b1;
        fh = aluA[3:0] < aluB[3:0]; fc = aluA < aluB;
      end
      4'd3: begin
        t  = {1'b0, aluA} - {1'b0, aluB} - {8'h00, aluCarry}; fn = 1'b1;
        fh = {1'b0, aluA[3:0]} < ({1'b0, aluB[3:0]} + {4'h0, aluCarry});
        fc = {1'b0, aluA} < ({1'b0, aluB} + {8'h00, aluCarry});
      end
      4'd5: begin t = {1'b0, aluA & aluB}; fh = 1'b1; end
      4'd6: t = {1'b0, aluA ^ aluB};
      4'd7: t = {1'b0, aluA | aluB};
      4'd8: begin t = {1'b0, aluA[6:0], aluCarry}; fc = aluA[7]; end
      4'd9: begin t = {1'b0, aluCarry, aluA[7:1]}; fc = aluA[0]; end
      default: t = 9'h1FF;
    endcase
    fz       = (t[7:0] == 8'h00);
    aluRes   = t[7:0];
    aluFlags = {fz, fn, fh, fc, 4'hA};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns one cycle after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic src, input logic [7:0] opnd,
                       input logic [15:0] addr);
    reqValid   = 1'b1;
    reqOp      = op;
    reqSrc     = src;
    reqOperand = opnd;
    reqAddr    = addr;
    step();
    reqValid = 1'b0;
  endtask

  initial begin
    resetN = 1'b1; reqValid = 1'b0; reqOp = 4'h0; reqSrc = 1'b0; reqOperand = 8'h00;
    reqAddr = 16'h0000; memRdValid = 1'b0; memRdData = 8'h00; loadA = 1'b0; loadData = 8'h00;

    // Reset values
    #1 resetN = 1'b0;
    #3;
    check("rst_a", regAOut, 8'h01);
    check("rst_f", regFOut, 8'hB0);
    check("rst_ready", reqReady, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_memreq", memRdReq, 1'b0);
    step();
    resetN = 1'b1;
    #1;
    check("post_rst_ready", reqReady, 1'b1);
    step();

    // ADD immediate 3A + C6
    loadA = 1'b1; loadData = 8'h3A;
    step();
    loadA = 1'b0;
    check("load_a", regAOut, 8'h3A);
    issue(4'd0, 1'b0, 8'hC6, 16'h0000);
    check("add_exec_ready", reqReady, 1'b0);
    check("add_alu_a", aluA, 8'h3A);
    check("add_alu_b", aluB, 8'hC6);
    check("add_alu_op", aluOp, 4'd0);
    check("add_alu_carry", aluCarry, 1'b1);
    step();
    check("add_a", regAOut, 8'h00);
    check("add_f", regFOut, 8'hB0);
    check("add_done", done, 1'b1);
    check("add_err", opErr, 1'b0);
    check("add_ready", reqReady, 1'b1);
    step();
    check("add_done_pulse", done, 1'b0);
    check("idle_alu_b", aluB, 8'h00);

    // Set F=10 with F0 + 20, then ADC E1 + 0F + carry
    loadA = 1'b1; loadData = 8'hF0;
    step();
    loadA = 1'b0;
    issue(4'd0, 1'b0, 8'h20, 16'h0000);
    step();
    check("pre_adc_a", regAOut, 8'h10);
    check("pre_adc_f", regFOut, 8'h10);
    loadA = 1'b1; loadData = 8'hE1;
    step();
    loadA = 1'b0;
    issue(4'd1, 1'b0, 8'h0F, 16'h0000);
    check("adc_alu_carry", aluCarry, 1'b1);
    step();
    check("adc_a", regAOut, 8'hF1);
    check("adc_f", regFOut, 8'h20);

    // CP with loadA on the accepting edge: EXEC sees the newly loaded A
    loadA = 1'b1; loadData = 8'h3C;
    issue(4'd4, 1'b0, 8'h2F, 16'h0000);
    loadA = 1'b0;
    check("cp_alu_a", aluA, 8'h3C);
    step();
    check("cp_f", regFOut, 8'h60);
    check("cp_a", regAOut, 8'h3C);
    check("cp_done", done, 1'b1);

    // Illegal opcode
    issue(4'hC, 1'b0, 8'h11, 16'h0000);
    step();
    check("ill_done", done, 1'b1);
    check("ill_err", opErr, 1'b1);
    check("ill_a", regAOut, 8'h3C);
    check("ill_f", regFOut, 8'h60);
    step();
    check("ill_err_pulse", opErr, 1'b0);

    // SUB 01 - 01 with B from memory (or treated as immediate when the memory path is absent)
    loadA = 1'b1; loadData = 8'h01;
    step();
    loadA = 1'b0;
`ifdef MEM_OPERAND_EN
    issue(4'd2, 1'b1, 8'hFF, 16'hC000);
    check("fetch_req", memRdReq, 1'b1);
    check("fetch_addr", memAddr, 16'hC000);
    check("fetch_ready", reqReady, 1'b0);
    step();
    step();
    memRdValid = 1'b1; memRdData = 8'h01;
    step();
    memRdValid = 1'b0; memRdData = 8'h00;
    check("msub_alu_b", aluB, 8'h01);
    check("msub_memreq_off", memRdReq, 1'b0);
`else
    issue(4'd2, 1'b1, 8'h01, 16'hC000);
    check("nomem_req", memRdReq, 1'b0);
    check("nomem_addr", memAddr, 16'h0000);
    check("nomem_alu_b", aluB, 8'h01);
`endif
    step();
    check("sub_a", regAOut, 8'h00);
    check("sub_f", regFOut, 8'hC0);
    check("sub_done", done, 1'b1);

`ifdef MEM_OPERAND_EN
    // Memory timeout: FETCH lasts MEM_TIMEOUT cycles, then done+opErr
    begin
      int n = 0;
      issue(4'd0, 1'b1, 8'h77, 16'hC001);
      while (memRdReq && n < 40) begin
        n++;
        step();
      end
      check("tmo_cycles", n, 15);
      check("tmo_done", done, 1'b1);
      check("tmo_err", opErr, 1'b1);
      check("tmo_a", regAOut, 8'h00);
      check("tmo_f", regFOut, 8'hC0);
      step();
    end
`endif

    // Back-to-back ADDs with reqValid held high
    reqValid = 1'b1; reqOp = 4'd0; reqSrc = 1'b0; reqOperand = 8'h01;
    step();
    reqOperand = 8'h02;
    check("b2b_exec_ready", reqReady, 1'b0);
    step();
    check("b2b_first_done", done, 1'b1);
    check("b2b_first_a", regAOut, 8'h01);
    check("b2b_first_f", regFOut, 8'h00);
    check("b2b_ready", reqReady, 1'b1);
    step();
    reqValid = 1'b0;
    check("b2b_gap_done", done, 1'b0);
    step();
    check("b2b_second_done", done, 1'b1);
    check("b2b_second_a", regAOut, 8'h03);

    // loadA during EXEC is ignored (CP leaves A alone)
    issue(4'd4, 1'b0, 8'h03, 16'h0000);
    loadA = 1'b1; loadData = 8'h55;
    step();
    loadA = 1'b0;
    check("ldexec_a", regAOut, 8'h03);
    check("ldexec_f", regFOut, 8'hC0);
    step();
    check("ldexec_a_later", regAOut, 8'h03);

    // Reset pulse mid-operation
`ifdef MEM_OPERAND_EN
    issue(4'd0, 1'b1, 8'h00, 16'hC002);
    check("midrst_fetching", memRdReq, 1'b1);
`else
    issue(4'd0, 1'b0, 8'h05, 16'h0000);
`endif
    resetN = 1'b0;
    #2;
    check("midrst_a", regAOut, 8'h01);
    check("midrst_f", regFOut, 8'hB0);
    check("midrst_memreq", memRdReq, 1'b0);
    check("midrst_ready", reqReady, 1'b0);
    resetN = 1'b1;
    step();
    check("midrst_no_done1", done, 1'b0);
    check("midrst_idle_ready", reqReady, 1'b1);
    step();
    check("midrst_no_done2", done, 1'b0);
    check("midrst_a_held", regAOut, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
